// File: rtl/sara_pkg.sv
// Shared types and elaboration helpers for the SARA/DAR corrector.
package sara_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPEC = 2'd1,
    WALK = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int MIN_GROUPS = 2;
  localparam int MIN_WINDOW = 2;

  function automatic int num_groups(input int size, input int groupsize);
    return size / groupsize;
  endfunction

  function automatic bit config_ok(input int size, input int groupsize, input int window);
    return (groupsize > 0) && (size % groupsize == 0) &&
           (size / groupsize >= MIN_GROUPS) &&
           (window >= MIN_WINDOW) && (window <= groupsize);
  endfunction

endpackage

// File: rtl/sara_dar_corrector_if.sv
// Producer/consumer handshake bundle for the SARA/DAR corrector.
interface sara_dar_corrector_if #(
  parameter int SIZE = 16
);
  import sara_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [SIZE:1]   a;
  logic [SIZE:1]   b;
  logic            cin;
  logic            mode;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE:1]   sum;
  logic            cout;
  logic            errflag;

  modport master (
    output in_valid, a, b, cin, mode, out_ready,
    input  in_ready, out_valid, sum, cout, errflag
  );

  modport slave (
    input  in_valid, a, b, cin, mode, out_ready,
    output in_ready, out_valid, sum, cout, errflag
  );

endinterface

// File: rtl/sara_dar_corrector_group_add.sv
// One group of the adder: ripple sum from generate/propagate bits plus the
// low-end propagate-chain flag used by the speculation.
module sara_group_add
  import sara_pkg::*;
#(
  parameter int GROUPSIZE = 8,
  parameter int WINDOW    = 2
) (
  input  logic [GROUPSIZE-1:0] i_g,
  input  logic [GROUPSIZE-1:0] i_p,
  input  logic                 i_cin,
  output logic [GROUPSIZE-1:0] o_sum,
  output logic                 o_cout,
  output logic                 o_chain
);

  logic w_carry;

  // Bit-serial ripple through the group, starting from the supplied carry-in.
  always_comb begin
    o_sum   = '0;
    w_carry = i_cin;
    for (int i = 0; i < GROUPSIZE; i++) begin
      o_sum[i] = i_p[i] ^ w_carry;
      w_carry  = i_g[i] | (i_p[i] & w_carry);
    end
    o_cout  = w_carry;
    o_chain = &i_p[WINDOW-1:0];
  end

endmodule

// File: rtl/sara_dar_corrector.sv
// SARA/DAR speculative adder front end with optional group-by-group repair.
module sara_dar_corrector
  import sara_pkg::*;
#(
  parameter int SIZE      = 16,
  parameter int GROUPSIZE = 8,
  parameter int WINDOW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sara_dar_corrector_if.slave  bus
);

  localparam int NG = num_groups(SIZE, GROUPSIZE);
  localparam int KW = (NG > 2) ? $clog2(NG) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NG - 1);

  if (!config_ok(SIZE, GROUPSIZE, WINDOW)) begin : g_bad_cfg
    $error("sara_dar_corrector: illegal SIZE/GROUPSIZE/WINDOW combination");
  end

  state_t          r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [SIZE:1]   r_a;
  logic [SIZE:1]   r_b;
  logic [SIZE:1]   r_sum;
  logic            r_cin;
  logic            r_mode;
  logic            r_cout;
  logic            r_err;
  logic            r_c;
  logic [NG-1:0]   r_sc;
  logic [NG-1:0]   r_ch;
  logic [KW-1:0]   r_k;

  logic [SIZE-1:0]      w_p;
  logic [SIZE-1:0]      w_g;
  logic [SIZE-1:0]      w_spec_sum;
  logic [NG-1:0]        w_sc;
  logic [NG-1:0]        w_ch;
  logic                 w_spec_cout;
  logic                 w_c0;
  logic [GROUPSIZE-1:0] w_walk_p;
  logic [GROUPSIZE-1:0] w_walk_g;
  logic [GROUPSIZE-1:0] w_walk_sum;
  logic                 w_walk_cout;
  logic                 w_walk_chain_unused;
  logic                 w_hi_clear;
  logic                 w_next_sc;
  logic                 w_walk_done;

  assign w_p = r_a ^ r_b;
  assign w_g = r_a & r_b;

  // Speculative pass: every group gets its own adder; a group whose low
  // WINDOW bits all propagate guesses its carry-in from the bit just below.
  for (genvar k = 0; k < NG; k++) begin : g_spec
    logic                 w_cin;
    logic                 w_cout;
    logic                 w_chain;
    logic [GROUPSIZE-1:0] w_sum;

    if (k == 0) begin : g_first
      assign w_cin = r_cin;
    end else begin : g_rest
      assign w_cin = w_chain ? w_g[k*GROUPSIZE-1] : g_spec[k-1].w_cout;
    end

    sara_group_add #(.GROUPSIZE(GROUPSIZE), .WINDOW(WINDOW)) u_add (
      .i_g     (w_g[k*GROUPSIZE +: GROUPSIZE]),
      .i_p     (w_p[k*GROUPSIZE +: GROUPSIZE]),
      .i_cin   (w_cin),
      .o_sum   (w_sum),
      .o_cout  (w_cout),
      .o_chain (w_chain)
    );

    assign w_spec_sum[k*GROUPSIZE +: GROUPSIZE] = w_sum;
    assign w_sc[k] = w_cin;
    assign w_ch[k] = w_chain;
  end

  assign w_spec_cout = g_spec[NG-1].w_cout;
  assign w_c0        = g_spec[0].w_cout;

  assign w_walk_p = w_p[int'(r_k)*GROUPSIZE +: GROUPSIZE];
  assign w_walk_g = w_g[int'(r_k)*GROUPSIZE +: GROUPSIZE];

  sara_group_add #(.GROUPSIZE(GROUPSIZE), .WINDOW(WINDOW)) u_walk_add (
    .i_g     (w_walk_g),
    .i_p     (w_walk_p),
    .i_cin   (r_c),
    .o_sum   (w_walk_sum),
    .o_cout  (w_walk_cout),
    .o_chain (w_walk_chain_unused)
  );

  // The walk can stop once the true carry agrees with the next guess and no
  // later group speculated off a chain.
  always_comb begin
    w_hi_clear = 1'b1;
    w_next_sc  = 1'b0;
    for (int j = 0; j < NG; j++) begin
      if (j > int'(r_k) + 1 && r_ch[j]) w_hi_clear = 1'b0;
      if (j == int'(r_k) + 1) w_next_sc = r_sc[j];
    end
    w_walk_done = (r_k == LAST_K) || ((w_walk_cout == w_next_sc) && w_hi_clear);
  end

  // Transaction FSM: accept, speculate, optionally repair, then hold result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cin       <= 1'b0;
      r_mode      <= 1'b0;
      r_cout      <= 1'b0;
      r_err       <= 1'b0;
      r_c         <= 1'b0;
      r_sc        <= '0;
      r_ch        <= '0;
      r_k         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_cin      <= bus.cin;
            r_mode     <= bus.mode;
            r_in_ready <= 1'b0;
            r_state    <= SPEC;
          end
        end
        SPEC: begin
          r_sum  <= w_spec_sum;
          r_cout <= w_spec_cout;
          r_sc   <= w_sc;
          r_ch   <= w_ch;
          r_c    <= w_c0;
          r_k    <= KW'(1);
          r_err  <= 1'b0;
          if (!r_mode || (w_ch[NG-1:1] == '0)) begin
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_state <= WALK;
          end
        end
        WALK: begin
          if (r_c != r_sc[r_k]) begin
            r_sum[int'(r_k)*GROUPSIZE+1 +: GROUPSIZE] <= w_walk_sum;
            r_err <= 1'b1;
          end
          r_c <= w_walk_cout;
          if (r_k == LAST_K) r_cout <= w_walk_cout;
          if (w_walk_done) begin
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.errflag   = r_err;

endmodule

// File: tb/tb_sara_dar_corrector.sv
// Scoreboard bench for sara_dar_corrector at the default 16/8/2 geometry.
module tb_sara_dar_corrector;

  localparam int SIZE = 16;
  localparam int GS   = 8;
  localparam int WIN  = 2;
  localparam int NG   = SIZE / GS;

  typedef struct packed {
    logic [SIZE:1] sum;
    logic          cout;
    logic          err;
    logic [7:0]    lat;
  } expect_t;

  logic clk;
  logic rst;
  int   vectorCount = 0;
  int   missCount   = 0;
  expect_t expQ[$];

  sara_dar_corrector_if #(.SIZE(SIZE)) bus ();

  sara_dar_corrector #(.SIZE(SIZE), .GROUPSIZE(GS), .WINDOW(WIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges beyond every bounded wait.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic expect_t mkExp(input logic [SIZE:1] sum, input logic cout,
                                    input logic err, input int lat);
    expect_t e;
    e.sum  = sum;
    e.cout = cout;
    e.err  = err;
    e.lat  = 8'(lat);
    return e;
  endfunction

  // Reference: exact ripple sum, speculative SARA/DAR sum and walk length.
  function automatic expect_t modelResult(input logic [SIZE:1] a, input logic [SIZE:1] b,
                                          input logic cin, input logic mode);
    expect_t       r;
    logic [SIZE-1:0] p, g, specSum, exactSum;
    logic [NG-1:0] sc, ch, ec;
    logic          c, specCarry, exactCout, clear, stop;
    int            k;
    p = a ^ b;
    g = a & b;
    c = cin;
    ec = '0;
    exactSum = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (i % GS == 0) ec[i/GS] = c;
      exactSum[i] = p[i] ^ c;
      c = g[i] | (p[i] & c);
    end
    exactCout = c;
    specCarry = cin;
    sc = '0;
    ch = '0;
    specSum = '0;
    for (int grp = 0; grp < NG; grp++) begin
      if (grp == 0) begin
        sc[0] = cin;
      end else begin
        ch[grp] = 1'b1;
        for (int w = 0; w < WIN; w++) ch[grp] = ch[grp] & p[grp*GS+w];
        sc[grp] = ch[grp] ? g[grp*GS-1] : specCarry;
      end
      c = sc[grp];
      for (int i = 0; i < GS; i++) begin
        specSum[grp*GS+i] = p[grp*GS+i] ^ c;
        c = g[grp*GS+i] | (p[grp*GS+i] & c);
      end
      specCarry = c;
    end
    if (!mode) begin
      r = mkExp(specSum, specCarry, 1'b0, 1);
    end else begin
      r = mkExp(exactSum, exactCout, |(ec ^ sc), 1);
      if (ch != '0) begin
        k = 1;
        stop = 1'b0;
        while (k < NG - 1 && !stop) begin
          clear = 1'b1;
          for (int j = 0; j < NG; j++) if (j > k + 1 && ch[j]) clear = 1'b0;
          if (ec[k+1] == sc[k+1] && clear) stop = 1'b1;
          else k++;
        end
        r.lat = 8'(1 + k);
      end
    end
    return r;
  endfunction

  // Present one operand pair, wait for acceptance, record what should come out.
  task automatic applyStimulus(input logic [SIZE:1] a, input logic [SIZE:1] b,
                               input logic cin, input logic mode, input expect_t e);
    int waitCycles = 0;
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.mode     = mode;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!bus.in_ready) begin
      checkValue("acceptTimeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    expQ.push_back(e);
    checkValue("inReadyBusy", 32'(bus.in_ready), 32'd0);
  endtask

  // Wait for the result, compare against the scoreboard, optionally stall it.
  task automatic checkOutput(input int holdCycles);
    expect_t e;
    int lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) begin
      checkValue("outValidTimeout", 32'(bus.out_valid), 32'd1);
      if (expQ.size() > 0) e = expQ.pop_front();
      return;
    end
    if (expQ.size() == 0) begin
      checkValue("unexpectedResult", 32'(expQ.size()), 32'd1);
      return;
    end
    e = expQ.pop_front();
    checkValue("latency", 32'(lat), 32'(e.lat));
    checkValue("sum", 32'(bus.sum), 32'(e.sum));
    checkValue("cout", 32'(bus.cout), 32'(e.cout));
    checkValue("errflag", 32'(bus.errflag), 32'(e.err));
    repeat (holdCycles) begin
      @(posedge clk);
      #1;
      checkValue("holdValid", 32'(bus.out_valid), 32'd1);
      checkValue("holdSum", 32'(bus.sum), 32'(e.sum));
      checkValue("holdCout", 32'(bus.cout), 32'(e.cout));
      checkValue("holdInReady", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkValue("postHsValid", 32'(bus.out_valid), 32'd0);
    checkValue("postHsInReady", 32'(bus.in_ready), 32'd1);
  endtask

  // Main sequence: reset, directed cases, stall, reset in WALK, random sweep.
  initial begin
    expect_t dropped;
    logic [SIZE:1] ra, rb;
    logic rcin, rmode;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkValue("rstInReady", 32'(bus.in_ready), 32'd1);
    checkValue("rstOutValid", 32'(bus.out_valid), 32'd0);
    checkValue("rstSum", 32'(bus.sum), 32'd0);
    checkValue("rstCout", 32'(bus.cout), 32'd0);
    checkValue("rstErr", 32'(bus.errflag), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(16'h1234, 16'h0F0F, 1'b0, 1'b1, mkExp(16'h2143, 1'b0, 1'b0, 1));
    checkOutput(0);
    applyStimulus(16'h03FF, 16'h0001, 1'b0, 1'b0, mkExp(16'h0300, 1'b0, 1'b0, 1));
    checkOutput(0);
    applyStimulus(16'h03FF, 16'h0001, 1'b0, 1'b1, mkExp(16'h0400, 1'b0, 1'b1, 2));
    checkOutput(0);
    applyStimulus(16'h0380, 16'h0080, 1'b0, 1'b1, mkExp(16'h0400, 1'b0, 1'b0, 2));
    checkOutput(0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1, mkExp(16'h0000, 1'b1, 1'b1, 2));
    checkOutput(0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, mkExp(16'hFF00, 1'b0, 1'b0, 1));
    checkOutput(5);

    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1, mkExp(16'h0000, 1'b1, 1'b1, 2));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkValue("walkRstOutValid", 32'(bus.out_valid), 32'd0);
    checkValue("walkRstInReady", 32'(bus.in_ready), 32'd1);
    checkValue("walkRstSum", 32'(bus.sum), 32'd0);
    checkValue("walkRstCout", 32'(bus.cout), 32'd0);
    checkValue("walkRstErr", 32'(bus.errflag), 32'd0);
    dropped = expQ.pop_back();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkValue("walkRstNoResult", 32'(bus.out_valid), 32'd0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1, mkExp(16'h0000, 1'b1, 1'b1, 2));
    checkOutput(0);

    for (int n = 0; n < 24; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 2 == 0) ra[10:9] = ~rb[10:9];
      rcin  = 1'($urandom_range(0, 1));
      rmode = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rcin, rmode, modelResult(ra, rb, rcin, rmode));
      checkOutput(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
